// File: rtl/op_dispatch_if.sv
// op_dispatch_if: command/engine handshake bundle for op_dispatch.
//   trig_*        single-cycle trigger pulses from command_fifo
//   base_addr_*   operand/result base addresses, valid with the trigger
//   eng_start     one-cycle launch pulse to the datapath engine
//   eng_op        latched opcode
//   eng_addr_*    latched addresses
//   eng_done      engine completion pulse
//   eng_abort     one-cycle abort pulse to the engine
//   mdmc_done     one-cycle completion pulse back to command_fifo
// Modports: slave = dispatcher side, master = command/engine side.
interface op_dispatch_if;
  logic       trig_ntt;
  logic       trig_intt;
  logic       trig_mul;
  logic       trig_constmul;
  logic       trig_dma;
  logic       trig_sqr;
  logic       trig_nmul;
  logic       trig_add;
  logic       trig_sub;
  logic [7:0] base_addr_a;
  logic [7:0] base_addr_b;
  logic [7:0] base_addr_r;
  logic       eng_start;
  logic [3:0] eng_op;
  logic [7:0] eng_addr_a;
  logic [7:0] eng_addr_b;
  logic [7:0] eng_addr_r;
  logic       eng_done;
  logic       eng_abort;
  logic       mdmc_done;

  modport slave (
    input  trig_ntt, trig_intt, trig_mul, trig_constmul, trig_dma,
           trig_sqr, trig_nmul, trig_add, trig_sub,
           base_addr_a, base_addr_b, base_addr_r, eng_done,
    output eng_start, eng_op, eng_addr_a, eng_addr_b, eng_addr_r,
           eng_abort, mdmc_done
  );

  modport master (
    output trig_ntt, trig_intt, trig_mul, trig_constmul, trig_dma,
           trig_sqr, trig_nmul, trig_add, trig_sub,
           base_addr_a, base_addr_b, base_addr_r, eng_done,
    input  eng_start, eng_op, eng_addr_a, eng_addr_b, eng_addr_r,
           eng_abort, mdmc_done
  );
endinterface

// File: rtl/op_dispatch.sv
// op_dispatch: captures one command from command_fifo, launches the
// datapath engine, waits for completion and reports back.
// Ports:
//   hclk        clock
//   hresetn     synchronous active-low reset
//   bus         op_dispatch_if.slave handshake bundle
//   clr_err     clears both sticky error flags
//   busy        high whenever the FSM is not IDLE
//   cmd_count   completed-command counter (wraps)
//   err_overlap sticky: trigger arrived while busy (trigger dropped)
//   err_timeout sticky: RUN exceeded TIMEOUT cycles
// Optional feature: define OPDISP_TIMEOUT_EN to enable the RUN watchdog.
module op_dispatch #(
  parameter logic [15:0] TIMEOUT = 16'd1024
) (
  input  logic          hclk,
  input  logic          hresetn,
  op_dispatch_if.slave  bus,
  input  logic          clr_err,
  output logic          busy,
  output logic [15:0]   cmd_count,
  output logic          err_overlap,
  output logic          err_timeout
);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_t;

  state_t     state;
  logic       trig_any;
  logic [3:0] dec_op;

  always_comb begin
    trig_any = bus.trig_ntt | bus.trig_intt | bus.trig_mul |
               bus.trig_constmul | bus.trig_dma | bus.trig_sqr |
               bus.trig_nmul | bus.trig_add | bus.trig_sub;
    dec_op = 4'd0;
    if      (bus.trig_constmul) dec_op = 4'd6;
    else if (bus.trig_sqr)      dec_op = 4'd8;
    else if (bus.trig_mul)      dec_op = 4'd3;
    else if (bus.trig_ntt)      dec_op = 4'd1;
    else if (bus.trig_intt)     dec_op = 4'd2;
    else if (bus.trig_add)      dec_op = 4'd4;
    else if (bus.trig_sub)      dec_op = 4'd5;
    else if (bus.trig_dma)      dec_op = 4'd7;
    else if (bus.trig_nmul)     dec_op = 4'd9;
  end

`ifdef OPDISP_TIMEOUT_EN
  logic [15:0] timer;
  logic        timeout_hit;

  // Combinational so the abort lands in the expiring RUN cycle itself and a
  // coincident eng_done can still suppress it.
  assign timeout_hit   = (state == RUN) && (timer == TIMEOUT - 16'd1) &&
                         !bus.eng_done;
  assign bus.eng_abort = timeout_hit;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign bus.eng_abort  = 1'b0;
  assign err_timeout    = 1'b0;
`endif

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state          <= IDLE;
      bus.eng_start  <= 1'b0;
      bus.mdmc_done  <= 1'b0;
      bus.eng_op     <= '0;
      bus.eng_addr_a <= '0;
      bus.eng_addr_b <= '0;
      bus.eng_addr_r <= '0;
      busy           <= 1'b0;
      cmd_count      <= '0;
      err_overlap    <= 1'b0;
`ifdef OPDISP_TIMEOUT_EN
      timer          <= '0;
      err_timeout    <= 1'b0;
`endif
    end else begin
      bus.eng_start <= 1'b0;
      bus.mdmc_done <= 1'b0;

      // Clear first so a coincident set condition wins.
      if (clr_err) err_overlap <= 1'b0;
      if (trig_any && (state != IDLE)) err_overlap <= 1'b1;
`ifdef OPDISP_TIMEOUT_EN
      if (clr_err) err_timeout <= 1'b0;
`endif

      case (state)
        IDLE: begin
          if (trig_any) begin
            state          <= LAUNCH;
            bus.eng_start  <= 1'b1;
            bus.eng_op     <= dec_op;
            bus.eng_addr_a <= bus.base_addr_a;
            bus.eng_addr_b <= bus.base_addr_b;
            bus.eng_addr_r <= bus.base_addr_r;
            busy           <= 1'b1;
          end
        end
        LAUNCH: begin
          if (bus.eng_done) begin
            state         <= DONE;
            bus.mdmc_done <= 1'b1;
            cmd_count     <= cmd_count + 16'd1;
          end else begin
            state <= RUN;
`ifdef OPDISP_TIMEOUT_EN
            timer <= '0;
`endif
          end
        end
        RUN: begin
          if (bus.eng_done) begin
            state         <= DONE;
            bus.mdmc_done <= 1'b1;
            cmd_count     <= cmd_count + 16'd1;
          end
`ifdef OPDISP_TIMEOUT_EN
          else if (timeout_hit) begin
            state         <= DONE;
            bus.mdmc_done <= 1'b1;
            cmd_count     <= cmd_count + 16'd1;
            err_timeout   <= 1'b1;
          end else begin
            timer <= timer + 16'd1;
          end
`endif
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
